// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one memory request/response port between the instruction fetch unit
// (IFU) and the load/store unit (LSU). Each requester issues a one-cycle
// reqValid pulse and later receives a one-cycle respValid pulse. Requests are
// latched into one pending slot per requester. An FSM grants one slot at a
// time, drives the memory handshake and routes the response back to the
// requester that owns the transaction. Only one memory transaction is
// outstanding at any time.
//
// Optional feature:
//   MEM_ARB_RR_EN  defined   -> round-robin arbitration on a tie (IFU wins
//                               the first tie after reset)
//                  undefined -> fixed priority, LSU wins every tie
//
// Ports:
//   clock, reset                   clock and asynchronous active-high reset
//   ifu_reqValid, ifu_addr         fetch request pulse and address
//   ifu_respValid, ifu_rdata       fetch response pulse and data
//   lsu_reqValid, lsu_wen,         load/store request pulse and fields
//   lsu_addr, lsu_wdata, lsu_wmask
//   lsu_respValid, lsu_rdata       load/store response pulse and data
//   mem_reqValid, mem_reqReady     memory request handshake
//   mem_wen, mem_addr,             issued request fields (registered)
//   mem_wdata, mem_wmask
//   mem_respValid, mem_rdata       memory response pulse and data
//   busy                           a transaction is pending or in flight
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ifu_reqValid,
    input  logic [ADDR_W-1:0]     ifu_addr,
    output logic                  ifu_respValid,
    output logic [DATA_W-1:0]     ifu_rdata,
    input  logic                  lsu_reqValid,
    input  logic                  lsu_wen,
    input  logic [ADDR_W-1:0]     lsu_addr,
    input  logic [DATA_W-1:0]     lsu_wdata,
    input  logic [DATA_W/8-1:0]   lsu_wmask,
    output logic                  lsu_respValid,
    output logic [DATA_W-1:0]     lsu_rdata,
    output logic                  mem_reqValid,
    input  logic                  mem_reqReady,
    output logic                  mem_wen,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wmask,
    input  logic                  mem_respValid,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  busy
);

    localparam int MASK_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    // Owner / grant encoding
    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    state_t              state_reg;
    logic                owner_reg;

    logic                ifu_pend_reg;
    logic [ADDR_W-1:0]   ifu_pend_addr_reg;

    logic                lsu_pend_reg;
    logic                lsu_pend_wen_reg;
    logic [ADDR_W-1:0]   lsu_pend_addr_reg;
    logic [DATA_W-1:0]   lsu_pend_wdata_reg;
    logic [MASK_W-1:0]   lsu_pend_wmask_reg;

`ifdef MEM_ARB_RR_EN
    logic                last_grant_reg;
`endif

    logic ifu_in_flight;
    logic lsu_in_flight;
    logic ifu_capture;
    logic lsu_capture;
    logic grant_lsu;
    logic do_grant;

    // A requester's own transaction is in flight from grant until the
    // response returns; a new pulse during that window is dropped.
    assign ifu_in_flight = (state_reg != IDLE) && (owner_reg == OWN_IFU);
    assign lsu_in_flight = (state_reg != IDLE) && (owner_reg == OWN_LSU);

    assign ifu_capture = ifu_reqValid && !ifu_pend_reg && !ifu_in_flight;
    assign lsu_capture = lsu_reqValid && !lsu_pend_reg && !lsu_in_flight;

    assign do_grant = (state_reg == IDLE) && (ifu_pend_reg || lsu_pend_reg);

    // Winner selection: only meaningful when do_grant is high.
    always_comb begin
        grant_lsu = lsu_pend_reg;
        if (ifu_pend_reg && lsu_pend_reg) begin
`ifdef MEM_ARB_RR_EN
            // The requester that did not get the previous grant wins a tie.
            grant_lsu = (last_grant_reg == OWN_IFU);
`else
            grant_lsu = 1'b1;
`endif
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg          <= IDLE;
            owner_reg          <= OWN_IFU;
            ifu_pend_reg       <= 1'b0;
            ifu_pend_addr_reg  <= '0;
            lsu_pend_reg       <= 1'b0;
            lsu_pend_wen_reg   <= 1'b0;
            lsu_pend_addr_reg  <= '0;
            lsu_pend_wdata_reg <= '0;
            lsu_pend_wmask_reg <= '0;
            mem_reqValid       <= 1'b0;
            mem_wen            <= 1'b0;
            mem_addr           <= '0;
            mem_wdata          <= '0;
            mem_wmask          <= '0;
`ifdef MEM_ARB_RR_EN
            last_grant_reg     <= OWN_LSU;
`endif
        end else begin
            // Pending slots. A capture can never coincide with the grant of
            // the same slot, because a pending slot ignores new pulses.
            if (ifu_capture) begin
                ifu_pend_reg      <= 1'b1;
                ifu_pend_addr_reg <= ifu_addr;
            end else if (do_grant && !grant_lsu) begin
                ifu_pend_reg      <= 1'b0;
            end

            if (lsu_capture) begin
                lsu_pend_reg       <= 1'b1;
                lsu_pend_wen_reg   <= lsu_wen;
                lsu_pend_addr_reg  <= lsu_addr;
                lsu_pend_wdata_reg <= lsu_wdata;
                lsu_pend_wmask_reg <= lsu_wmask;
            end else if (do_grant && grant_lsu) begin
                lsu_pend_reg       <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (do_grant) begin
                        state_reg    <= REQ;
                        mem_reqValid <= 1'b1;
                        if (grant_lsu) begin
                            owner_reg <= OWN_LSU;
                            mem_wen   <= lsu_pend_wen_reg;
                            mem_addr  <= lsu_pend_addr_reg;
                            mem_wdata <= lsu_pend_wdata_reg;
                            mem_wmask <= lsu_pend_wmask_reg;
                        end else begin
                            // Fetches are always reads with no write payload.
                            owner_reg <= OWN_IFU;
                            mem_wen   <= 1'b0;
                            mem_addr  <= ifu_pend_addr_reg;
                            mem_wdata <= '0;
                            mem_wmask <= '0;
                        end
`ifdef MEM_ARB_RR_EN
                        last_grant_reg <= grant_lsu ? OWN_LSU : OWN_IFU;
`endif
                    end
                end
                REQ: begin
                    // Fields stay frozen until the memory accepts.
                    if (mem_reqReady) begin
                        state_reg    <= WAIT;
                        mem_reqValid <= 1'b0;
                    end
                end
                WAIT: begin
                    if (mem_respValid) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg    <= IDLE;
                    mem_reqValid <= 1'b0;
                end
            endcase
        end
    end

    // Responses are forwarded in the same cycle as mem_respValid; a response
    // outside WAIT is a stray and is dropped.
    assign ifu_respValid = (state_reg == WAIT) && mem_respValid && (owner_reg == OWN_IFU);
    assign lsu_respValid = (state_reg == WAIT) && mem_respValid && (owner_reg == OWN_LSU);

    assign ifu_rdata = ifu_respValid ? mem_rdata : '0;
    assign lsu_rdata = lsu_respValid ? mem_rdata : '0;

    assign busy = (state_reg != IDLE) || ifu_pend_reg || lsu_pend_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Self-checking bench for mem_arbiter. Stimulus processes drive the two
// requesters and a memory responder; a negedge monitor keeps a transaction
// level reference model (per-requester outstanding request with its capture
// cycle, grant rules, expected-response queues) and compares every cycle.
// Honours MEM_ARB_RR_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = DW / 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          ifu_reqValid;
    logic [AW-1:0] ifu_addr;
    logic          ifu_respValid;
    logic [DW-1:0] ifu_rdata;
    logic          lsu_reqValid;
    logic          lsu_wen;
    logic [AW-1:0] lsu_addr;
    logic [DW-1:0] lsu_wdata;
    logic [MW-1:0] lsu_wmask;
    logic          lsu_respValid;
    logic [DW-1:0] lsu_rdata;
    logic          mem_reqValid;
    logic          mem_reqReady;
    logic          mem_wen;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [MW-1:0] mem_wmask;
    logic          mem_respValid;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock         (clock),
        .reset         (reset),
        .ifu_reqValid  (ifu_reqValid),
        .ifu_addr      (ifu_addr),
        .ifu_respValid (ifu_respValid),
        .ifu_rdata     (ifu_rdata),
        .lsu_reqValid  (lsu_reqValid),
        .lsu_wen       (lsu_wen),
        .lsu_addr      (lsu_addr),
        .lsu_wdata     (lsu_wdata),
        .lsu_wmask     (lsu_wmask),
        .lsu_respValid (lsu_respValid),
        .lsu_rdata     (lsu_rdata),
        .mem_reqValid  (mem_reqValid),
        .mem_reqReady  (mem_reqReady),
        .mem_wen       (mem_wen),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wmask     (mem_wmask),
        .mem_respValid (mem_respValid),
        .mem_rdata     (mem_rdata),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    endtask

    // Memory contents as seen by the bench: one fixed word, hash elsewhere.
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0000_0413;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    // ------------------------------------------------------------------
    // Reference model state (written only by the monitor)
    // index 0 = IFU, 1 = LSU
    // ------------------------------------------------------------------
    bit            o_valid   [2];
    int            o_cyc     [2];
    bit            o_granted [2];
    logic          o_wen     [2];
    logic [31:0]   o_addr    [2];
    logic [31:0]   o_wdata   [2];
    logic [3:0]    o_wmask   [2];
    logic [31:0]   exp_q_ifu [$];
    logic [31:0]   exp_q_lsu [$];
    bit            req_phase;
    bit            wait_phase;
    bit            prev_idle;
    int            owner;
    int            last_grant;
    logic          lat_wen;
    logic [31:0]   lat_addr;
    logic [31:0]   lat_wdata;
    logic [3:0]    lat_wmask;

    int            mon_c;
    bit            mon_cand0, mon_cand1, mon_rise, mon_idle, mon_busy;
    bit            mon_e_ifu, mon_e_lsu;
    int            mon_win;
    logic [31:0]   mon_ev;

    always @(negedge clock) begin
        if (reset) begin
            check("reset_ctrl", {mem_reqValid, mem_wen, busy, ifu_respValid, lsu_respValid, mem_wmask}, '0);
            check("reset_fields", {mem_addr, mem_wdata}, '0);
            check("reset_rdata", {ifu_rdata, lsu_rdata}, '0);
            for (int x = 0; x < 2; x++) begin
                o_valid[x]   = 0;
                o_granted[x] = 0;
            end
            exp_q_ifu.delete();
            exp_q_lsu.delete();
            req_phase  = 0;
            wait_phase = 0;
            prev_idle  = 1;
            owner      = 0;
            last_grant = 1;
        end else begin
            mon_c = cyc;
            // Grant decision made in the previous (IDLE) cycle from requests
            // captured at least one cycle before that.
            mon_cand0 = o_valid[0] && !o_granted[0] && (o_cyc[0] <= mon_c - 2);
            mon_cand1 = o_valid[1] && !o_granted[1] && (o_cyc[1] <= mon_c - 2);
            mon_rise  = prev_idle && (mon_cand0 || mon_cand1);
            check("mem_reqValid", mem_reqValid, req_phase || mon_rise);

            if (mon_rise) begin
                if (mon_cand0 && mon_cand1) begin
`ifdef MEM_ARB_RR_EN
                    mon_win = (last_grant == 1) ? 0 : 1;
`else
                    mon_win = 1;
`endif
                end else begin
                    mon_win = mon_cand1 ? 1 : 0;
                end
                last_grant         = mon_win;
                owner              = mon_win;
                o_granted[mon_win] = 1;
                req_phase          = 1;
                lat_addr           = o_addr[mon_win];
                lat_wen            = (mon_win == 1) ? o_wen[1]   : 1'b0;
                lat_wdata          = (mon_win == 1) ? o_wdata[1] : 32'h0;
                lat_wmask          = (mon_win == 1) ? o_wmask[1] : 4'h0;
                $display("cycle %0d: grant %s addr=0x%08h wen=%0b wdata=0x%08h wmask=0x%0h",
                         mon_c, (mon_win == 1) ? "LSU" : "IFU", lat_addr, lat_wen, lat_wdata, lat_wmask);
            end

            if (req_phase)
                check("mem_fields", {mem_wen, mem_wmask, mem_addr, mem_wdata},
                      {lat_wen, lat_wmask, lat_addr, lat_wdata});

            mon_busy = req_phase || wait_phase ||
                       (o_valid[0] && !o_granted[0] && (o_cyc[0] <= mon_c - 1)) ||
                       (o_valid[1] && !o_granted[1] && (o_cyc[1] <= mon_c - 1));
            check("busy", busy, mon_busy);
            mon_idle = !(req_phase || wait_phase);

            // Request capture: one outstanding request per requester.
            if (ifu_reqValid) begin
                if (!o_valid[0]) begin
                    o_valid[0] = 1; o_cyc[0] = mon_c; o_granted[0] = 0;
                    o_wen[0] = 0; o_addr[0] = ifu_addr; o_wdata[0] = 0; o_wmask[0] = 0;
                    exp_q_ifu.push_back(mem_fn(ifu_addr));
                end else begin
                    $display("cycle %0d: IFU duplicate request dropped", mon_c);
                end
            end
            if (lsu_reqValid) begin
                if (!o_valid[1]) begin
                    o_valid[1] = 1; o_cyc[1] = mon_c; o_granted[1] = 0;
                    o_wen[1] = lsu_wen; o_addr[1] = lsu_addr; o_wdata[1] = lsu_wdata; o_wmask[1] = lsu_wmask;
                    exp_q_lsu.push_back(mem_fn(lsu_addr));
                end else begin
                    $display("cycle %0d: LSU duplicate request dropped", mon_c);
                end
            end

            // Responses
            mon_e_ifu = wait_phase && mem_respValid && (owner == 0);
            mon_e_lsu = wait_phase && mem_respValid && (owner == 1);
            check("ifu_respValid", ifu_respValid, mon_e_ifu);
            check("lsu_respValid", lsu_respValid, mon_e_lsu);

            if (ifu_respValid || mon_e_ifu) begin
                if (exp_q_ifu.size() == 0) begin
                    n_checks++;
                    $display("FAIL ifu_resp_queue cycle %0d: got response 0x%0h, expected no response", mon_c, ifu_rdata);
                end else begin
                    mon_ev = exp_q_ifu.pop_front();
                    check("ifu_rdata", ifu_rdata, mon_ev);
                end
            end else begin
                check("ifu_rdata_idle", ifu_rdata, 0);
            end
            if (lsu_respValid || mon_e_lsu) begin
                if (exp_q_lsu.size() == 0) begin
                    n_checks++;
                    $display("FAIL lsu_resp_queue cycle %0d: got response 0x%0h, expected no response", mon_c, lsu_rdata);
                end else begin
                    mon_ev = exp_q_lsu.pop_front();
                    check("lsu_rdata", lsu_rdata, mon_ev);
                end
            end else begin
                check("lsu_rdata_idle", lsu_rdata, 0);
            end

            if (mon_e_ifu || mon_e_lsu) begin
                $display("cycle %0d: response to %s rdata=0x%08h", mon_c, (owner == 1) ? "LSU" : "IFU", mem_rdata);
                o_valid[owner] = 0;
                wait_phase     = 0;
            end else if (mem_respValid && !wait_phase) begin
                $display("cycle %0d: stray memory response ignored", mon_c);
            end

            // Accept moves the transaction to WAIT from the next cycle on.
            if (req_phase && mem_reqReady) begin
                req_phase  = 0;
                wait_phase = 1;
            end

            prev_idle = mon_idle;
        end
    end

    // ------------------------------------------------------------------
    // Memory responder
    // ------------------------------------------------------------------
    bit          rand_mem      = 0;
    int          rdy_delay_cfg = 0;
    int          lat_cfg       = 0;
    int          stray_at      = -1;
    bit          r_pend;
    int          r_cnt, r_lim, l_cnt;
    logic [31:0] r_addr;

    initial begin
        mem_reqReady  = 0;
        mem_respValid = 0;
        mem_rdata     = 0;
        r_pend = 0; r_cnt = 0; r_lim = 0; l_cnt = 0; r_addr = 0;
        forever begin
            @(posedge clock);
            #1;
            mem_reqReady  = 0;
            mem_respValid = 0;
            mem_rdata     = $urandom;
            if (reset) begin
                r_pend = 0;
                r_cnt  = 0;
            end else if (cyc == stray_at) begin
                mem_respValid = 1;
            end else if (r_pend) begin
                if (l_cnt == 0) begin
                    mem_respValid = 1;
                    mem_rdata     = mem_fn(r_addr);
                    r_pend        = 0;
                end else begin
                    l_cnt--;
                end
            end else if (mem_reqValid) begin
                if (r_cnt == 0) r_lim = rand_mem ? int'($urandom_range(0, 3)) : rdy_delay_cfg;
                if (r_cnt >= r_lim) begin
                    mem_reqReady = 1;
                    r_pend       = 1;
                    r_addr       = mem_addr;
                    l_cnt        = rand_mem ? int'($urandom_range(0, 3)) : lat_cfg;
                    r_cnt        = 0;
                end else begin
                    r_cnt++;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Requester stimulus
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clock);
        #1;
        ifu_reqValid = 0;
        lsu_reqValid = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    initial begin
        reset        = 1;
        ifu_reqValid = 0; ifu_addr  = 0;
        lsu_reqValid = 0; lsu_wen   = 0; lsu_addr = 0; lsu_wdata = 0; lsu_wmask = 0;
        idle(3);
        reset = 0;
        idle(2);

        // IFU alone, immediate accept, response 3 cycles after issue
        rdy_delay_cfg = 0; lat_cfg = 2;
        step(); ifu_reqValid = 1; ifu_addr = 32'h8000_0000;
        idle(10);

        // Simultaneous requests (repeated ties)
        for (int k = 0; k < 3; k++) begin
            step();
            ifu_reqValid = 1; ifu_addr = 32'h0000_0100 + 32'(k * 4);
            lsu_reqValid = 1; lsu_wen = 1; lsu_addr = 32'h0000_0200 + 32'(k * 4);
            lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF;
            idle(14);
        end

        // Backpressure: memory refuses for 4 cycles
        rdy_delay_cfg = 4; lat_cfg = 1;
        step(); lsu_reqValid = 1; lsu_wen = 0; lsu_addr = 32'h0000_0300; lsu_wdata = 32'h1234_5678; lsu_wmask = 4'h3;
        idle(14);

        // Stray response in IDLE, then a duplicate fetch while in flight
        rdy_delay_cfg = 0; lat_cfg = 3;
        step(); stray_at = cyc + 1;
        idle(3);
        step(); ifu_reqValid = 1; ifu_addr = 32'h0000_0400;
        idle(3);
        ifu_reqValid = 1; ifu_addr = 32'h0000_0404;
        idle(12);

        // Reset in WAIT, then a late response
        rdy_delay_cfg = 0; lat_cfg = 6;
        step(); ifu_reqValid = 1; ifu_addr = 32'h0000_0500;
        idle(5);
        reset = 1;
        idle(2);
        reset = 0;
        stray_at = cyc + 2;
        idle(8);

        // Randomized traffic: continuous re-requests first, then sparse
        rand_mem = 1;
        for (int i = 0; i < 1500; i++) begin
            step();
            if ((!o_valid[0] && ($urandom_range(0, 99) < ((i < 300) ? 100 : 40))) ||
                ($urandom_range(0, 99) < 3)) begin
                ifu_reqValid = 1;
                ifu_addr     = $urandom;
            end
            if ((!o_valid[1] && ($urandom_range(0, 99) < ((i < 300) ? 100 : 40))) ||
                ($urandom_range(0, 99) < 3)) begin
                lsu_reqValid = 1;
                lsu_wen      = 1'($urandom);
                lsu_addr     = $urandom;
                lsu_wdata    = $urandom;
                lsu_wmask    = 4'($urandom);
            end
        end
        idle(20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
